multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through IF/ID/EX/MEM/WB and generates IRWrite for the instruction decoder.
- Drives PC-update, register-file write, write-back select and memory request strobes.
- Handles ready-handshake stalls on both memories, halt, illegal opcodes and the retired-instruction count.

---
 rtl/multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM of the multi-cycle RV32I core. Every instruction walks
// through IF -> ID -> EX -> (MEM) -> (WB) and the FSM produces the strobes that
// steer the datapath in each step: instruction fetch request and IR load,
// data memory request / write, register-file write, write-back and next-PC
// selection, and the PC update itself. It also implements the ready
// handshakes with both memories (with an optional stall timeout), the halt
// request, illegal-opcode reporting and a retired-instruction counter.
//
// Parameters
//   CNT_W        width of the retired-instruction counter NUM_INST
//   MEM_TIMEOUT  stall cycles allowed on a memory before giving up (0 = never)
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous active-high reset
//   OPCODE       INSTR[6:0] from the instruction register (valid from ID on)
//   BR_TAKEN     branch condition from the ALU (valid in EX)
//   HALT_REQ     halt-pattern detect (sampled in ID)
//   I_MEM_READY  instruction memory data valid
//   D_MEM_READY  data memory access complete
//   I_MEM_REQ    instruction fetch request
//   IRWrite      load instruction register / enable decoder
//   D_MEM_REQ    data memory request
//   D_MEM_WE     data memory write (stores)
//   RF_WE        register-file write enable
//   WB_SEL       write-back select: 0 = ALU, 1 = load data, 2 = PC+4
//   PCWrite      PC register update
//   PC_SEL       next PC: 0 = PC+4, 1 = PC+IMM, 2 = (rs1+IMM) & ~1
//   ILLEGAL      one-cycle pulse on an unknown opcode
//   HALTED       sticky halt flag
//   ERR          sticky memory-timeout flag
//   NUM_INST     retired-instruction count (wraps)
//   STATE        debug view of the FSM: IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic             BR_TAKEN,
  input  logic             HALT_REQ,
  input  logic             I_MEM_READY,
  input  logic             D_MEM_READY,
  output logic             I_MEM_REQ,
  output logic             IRWrite,
  output logic             D_MEM_REQ,
  output logic             D_MEM_WE,
  output logic             RF_WE,
  output logic [1:0]       WB_SEL,
  output logic             PCWrite,
  output logic [1:0]       PC_SEL,
  output logic             ILLEGAL,
  output logic             HALTED,
  output logic             ERR,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [2:0]       STATE
);

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // The wait counter only has to count up to MEM_TIMEOUT-1: the stall cycle
  // that would bring it to MEM_TIMEOUT is the one that branches to HALT.
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [6:0]          opcode_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [CNT_W-1:0]    num_inst_reg;
  logic                halted_reg;
  logic                err_reg;

  // Raw (pre-reset-gating) strobes from the next-state logic
  logic                i_mem_req;
  logic                ir_write;
  logic                d_mem_req;
  logic                d_mem_we;
  logic                rf_we;
  logic [1:0]          wb_sel;
  logic                pc_write;
  logic [1:0]          pc_sel;
  logic                illegal;
  logic                stall;
  logic                timeout;
  logic                retire;

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_known = 1'b1;
      default:                           opcode_known = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State register and registered bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IF;
      opcode_reg   <= '0;
      wait_cnt_reg <= '0;
      num_inst_reg <= '0;
      halted_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Later stages decode from this copy; OPCODE itself is only trusted in ID.
      if (state_reg == S_ID) begin
        opcode_reg <= OPCODE;
      end

      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (stall) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end

      if (retire) begin
        num_inst_reg <= num_inst_reg + CNT_W'(1);
      end

      // Any route into HALT (request or timeout) raises the sticky flag.
      if (state_next == S_HALT) begin
        halted_reg <= 1'b1;
      end

      if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe generation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    i_mem_req  = 1'b0;
    ir_write   = 1'b0;
    d_mem_req  = 1'b0;
    d_mem_we   = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    pc_write   = 1'b0;
    pc_sel     = PC_PLUS4;
    illegal    = 1'b0;
    stall      = 1'b0;
    timeout    = 1'b0;

    case (state_reg)
      S_IF: begin
        i_mem_req = 1'b1;
        ir_write  = I_MEM_READY;
        if (I_MEM_READY) begin
          state_next = S_ID;
        end else begin
          stall = 1'b1;
        end
      end

      S_ID: begin
        if (HALT_REQ) begin
          state_next = S_HALT;
        end else if (opcode_known(OPCODE)) begin
          state_next = S_EX;
        end else begin
          // Skip the bad word: advance the PC but do not count it as retired.
          illegal    = 1'b1;
          pc_write   = 1'b1;
          pc_sel     = PC_PLUS4;
          state_next = S_IF;
        end
      end

      S_EX: begin
        if (opcode_reg == OP_BRANCH) begin
          pc_write   = 1'b1;
          pc_sel     = BR_TAKEN ? PC_REL : PC_PLUS4;
          state_next = S_IF;
        end else if (opcode_reg == OP_LOAD || opcode_reg == OP_STORE) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end

      S_MEM: begin
        d_mem_req = 1'b1;
        d_mem_we  = (opcode_reg == OP_STORE);
        if (D_MEM_READY) begin
          if (opcode_reg == OP_STORE) begin
            pc_write   = 1'b1;
            pc_sel     = PC_PLUS4;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else begin
          stall = 1'b1;
        end
      end

      S_WB: begin
        rf_we    = 1'b1;
        pc_write = 1'b1;
        case (opcode_reg)
          OP_LOAD:          wb_sel = WB_LOAD;
          OP_JAL, OP_JALR:  wb_sel = WB_PC4;
          default:          wb_sel = WB_ALU;
        endcase
        case (opcode_reg)
          OP_JAL:  pc_sel = PC_REL;
          OP_JALR: pc_sel = PC_JALR;
          default: pc_sel = PC_PLUS4;
        endcase
        state_next = S_IF;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IF;
      end
    endcase

    // The stall cycle that would make the counter reach MEM_TIMEOUT aborts.
    // Strobes of that cycle stay as they were so the stall looks uniform.
    if (TIMEOUT_EN && stall && (wait_cnt_reg == WAIT_LAST)) begin
      timeout    = 1'b1;
      state_next = S_HALT;
    end
  end

  assign retire = pc_write & ~illegal;

  // ---------------------------------------------------------------------------
  // Outputs: combinational strobes are silenced during reset so an in-flight
  // instruction can never leave a partial write behind.
  // ---------------------------------------------------------------------------
  assign I_MEM_REQ = i_mem_req & ~RST;
  assign IRWrite   = ir_write  & ~RST;
  assign D_MEM_REQ = d_mem_req & ~RST;
  assign D_MEM_WE  = d_mem_we  & ~RST;
  assign RF_WE     = rf_we     & ~RST;
  assign WB_SEL    = RST ? 2'd0 : wb_sel;
  assign PCWrite   = pc_write  & ~RST;
  assign PC_SEL    = RST ? 2'd0 : pc_sel;
  assign ILLEGAL   = illegal   & ~RST;
  assign STATE     = RST ? 3'd0 : state_reg;

  assign HALTED    = halted_reg;
  assign ERR       = err_reg;
  assign NUM_INST  = num_inst_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. The stimulus side walks an
// instruction-level model: for each instruction it decides how many fetch and
// data stalls to apply, drives the inputs cycle by cycle and pushes the
// expected output vector of every cycle plus one record per finished
// instruction. Inputs that the current step must ignore are driven with random
// noise. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W       = 4;   // narrow so the counter wraps during the run
  localparam int MEM_TIMEOUT = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             br_taken;
  logic             halt_req;
  logic             i_mem_ready;
  logic             d_mem_ready;
  logic             i_mem_req;
  logic             ir_write;
  logic             d_mem_req;
  logic             d_mem_we;
  logic             rf_we;
  logic [1:0]       wb_sel;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             illegal;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] num_inst;
  logic [2:0]       state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .BR_TAKEN(br_taken),
    .HALT_REQ(halt_req), .I_MEM_READY(i_mem_ready), .D_MEM_READY(d_mem_ready),
    .I_MEM_REQ(i_mem_req), .IRWrite(ir_write), .D_MEM_REQ(d_mem_req),
    .D_MEM_WE(d_mem_we), .RF_WE(rf_we), .WB_SEL(wb_sel), .PCWrite(pc_write),
    .PC_SEL(pc_sel), .ILLEGAL(illegal), .HALTED(halted), .ERR(err),
    .NUM_INST(num_inst), .STATE(state)
  );

  typedef struct packed {
    logic             i_req;
    logic             ir_we;
    logic             d_req;
    logic             d_we;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             illegal;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] num;
    logic [2:0]       state;
  } obs_t;

  typedef struct packed {
    logic [7:0] len;
    logic [6:0] opc;
  } txn_t;

  obs_t exp_q[$];
  txn_t txn_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_len = 0;
  bit   stim_done = 1'b0;

  // Architectural view kept by the model
  logic [CNT_W-1:0] m_num;
  logic             m_halted;
  logic             m_err;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    logic [6:0] ops [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int i = 0; i < 9; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected vector with every strobe low and the registered flags from the model
  function automatic obs_t idle_obs(input logic [2:0] st);
    obs_t o;
    o        = '0;
    o.state  = st;
    o.halted = m_halted;
    o.err    = m_err;
    o.num    = m_num;
    return o;
  endfunction

  task automatic drive(input logic r, input logic [6:0] opc, input logic br,
                       input logic hreq, input logic ir, input logic dr,
                       input obs_t e);
    @(posedge clk);
    #1;
    rst         = r;
    opcode      = opc;
    br_taken    = br;
    halt_req    = hreq;
    i_mem_ready = ir;
    d_mem_ready = dr;
    exp_q.push_back(e);
  endtask

  task automatic push_txn(input int len, input logic [6:0] opc);
    txn_t t;
    t.len = 8'(len);
    t.opc = opc;
    txn_q.push_back(t);
  endtask

  task automatic reset_cycle();
    drive(1'b1, ro(), rb(), rb(), rb(), rb(), idle_obs(3'd0));
    m_num    = '0;
    m_halted = 1'b0;
    m_err    = 1'b0;
  endtask

  // Sit in HALT with noisy inputs, then leave through reset
  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, ro(), rb(), rb(), rb(), rb(), idle_obs(3'd5));
    reset_cycle();
  endtask

  // One instruction: iw fetch stalls, dw data stalls; abort_at >= 0 replaces
  // that MEM cycle with a reset pulse.
  task automatic run_instr(input logic [6:0] opc, input logic br, input int iw,
                           input int dw, input int abort_at);
    obs_t e;
    int   len;
    bit   ld, st, jal, jalr, is_br;
    len   = 0;
    ld    = (opc == OP_LOAD);
    st    = (opc == OP_STORE);
    jal   = (opc == OP_JAL);
    jalr  = (opc == OP_JALR);
    is_br = (opc == OP_BRANCH);

    for (int k = 0; k <= iw; k++) begin
      e       = idle_obs(3'd0);
      e.i_req = 1'b1;
      e.ir_we = (k == iw);
      drive(1'b0, ro(), rb(), rb(), k == iw, rb(), e);
      len++;
      if (k != iw && k + 1 == MEM_TIMEOUT) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
        halt_then_reset(6);
        return;
      end
    end

    e = idle_obs(3'd1);
    if (!is_known(opc)) begin
      e.illegal = 1'b1;
      e.pc_we   = 1'b1;
    end
    drive(1'b0, opc, rb(), 1'b0, rb(), rb(), e);
    len++;
    if (!is_known(opc)) begin
      push_txn(len, opc);
      return;
    end

    e = idle_obs(3'd2);
    if (is_br) begin
      e.pc_we  = 1'b1;
      e.pc_sel = br ? 2'd1 : 2'd0;
    end
    drive(1'b0, ro(), br, rb(), rb(), rb(), e);
    len++;
    if (is_br) begin
      push_txn(len, opc);
      m_num = m_num + 1'b1;
      return;
    end

    if (ld || st) begin
      for (int k = 0; k <= dw; k++) begin
        if (k == abort_at) begin
          reset_cycle();
          return;
        end
        e       = idle_obs(3'd3);
        e.d_req = 1'b1;
        e.d_we  = st;
        e.pc_we = st && (k == dw);
        drive(1'b0, ro(), rb(), rb(), rb(), k == dw, e);
        len++;
        if (k != dw && k + 1 == MEM_TIMEOUT) begin
          m_halted = 1'b1;
          m_err    = 1'b1;
          halt_then_reset(6);
          return;
        end
      end
      if (st) begin
        push_txn(len, opc);
        m_num = m_num + 1'b1;
        return;
      end
    end

    e        = idle_obs(3'd4);
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
    e.pc_sel = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
    drive(1'b0, ro(), rb(), rb(), rb(), rb(), e);
    len++;
    push_txn(len, opc);
    m_num = m_num + 1'b1;
  endtask

  task automatic run_halt_req(input logic [6:0] opc);
    obs_t e;
    e       = idle_obs(3'd0);
    e.i_req = 1'b1;
    e.ir_we = 1'b1;
    drive(1'b0, ro(), rb(), rb(), 1'b1, rb(), e);
    drive(1'b0, opc, rb(), 1'b1, rb(), rb(), idle_obs(3'd1));
    m_halted = 1'b1;
    halt_then_reset(12);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    txn_t t;
    if (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      a.i_req   = i_mem_req;
      a.ir_we   = ir_write;
      a.d_req   = d_mem_req;
      a.d_we    = d_mem_we;
      a.rf_we   = rf_we;
      a.wb_sel  = wb_sel;
      a.pc_we   = pc_write;
      a.pc_sel  = pc_sel;
      a.illegal = illegal;
      a.halted  = halted;
      a.err     = err;
      a.num     = num_inst;
      a.state   = state;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t actual{ireq=%b irw=%b dreq=%b dwe=%b rfwe=%b wbsel=%0d pcw=%b pcsel=%0d ill=%b halt=%b err=%b num=%0d st=%0d} required{ireq=%b irw=%b dreq=%b dwe=%b rfwe=%b wbsel=%0d pcw=%b pcsel=%0d ill=%b halt=%b err=%b num=%0d st=%0d}",
                 $time, a.i_req, a.ir_we, a.d_req, a.d_we, a.rf_we, a.wb_sel, a.pc_we, a.pc_sel,
                 a.illegal, a.halted, a.err, a.num, a.state,
                 e.i_req, e.ir_we, e.d_req, e.d_we, e.rf_we, e.wb_sel, e.pc_we, e.pc_sel,
                 e.illegal, e.halted, e.err, e.num, e.state);
      end
    end

    // Instruction-level view: length of each instruction ending in a PC update
    if (rst) begin
      mon_len = 0;
    end else begin
      mon_len++;
      if (pc_write === 1'b1) begin
        checks++;
        if (txn_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected t=%0t actual PCWrite=1 required no instruction end", $time);
        end else begin
          t = txn_q.pop_front();
          if (mon_len != int'(t.len)) begin
            errors++;
            $display("FAIL txn_length opc=%b actual %0d cycles required %0d", t.opc, mon_len, t.len);
          end else begin
            $display("txn opc=%b cycles=%0d pc_sel=%0d illegal=%b num_inst=%0d",
                     t.opc, mon_len, pc_sel, illegal, num_inst);
          end
        end
        mon_len = 0;
      end
    end

    if (stim_done && exp_q.size() == 0) begin
      checks++;
      if (txn_q.size() != 0) begin
        errors++;
        $display("FAIL txn_drain actual %0d instructions never ended required 0", txn_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [6:0] ops [9];
    logic [6:0] opc;
    int         sel, iw, dw;
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    rst         = 1'b1;
    opcode      = '0;
    br_taken    = 1'b0;
    halt_req    = 1'b0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    m_num       = '0;
    m_halted    = 1'b0;
    m_err       = 1'b0;

    for (int i = 0; i < 3; i++) reset_cycle();

    // Directed sequence
    run_instr(OP_IMM,    1'b0, 0, 0, -1);
    run_instr(OP_R,      1'b0, 0, 0, -1);
    run_instr(OP_LOAD,   1'b0, 0, 3, -1);
    run_instr(OP_BRANCH, 1'b1, 0, 0, -1);
    run_instr(OP_BRANCH, 1'b0, 0, 0, -1);
    run_instr(OP_JALR,   1'b0, 0, 0, -1);
    run_instr(OP_STORE,  1'b0, 1, 2, -1);
    run_instr(OP_JAL,    1'b0, 0, 0, -1);
    run_instr(OP_LUI,    1'b0, 2, 0, -1);
    run_instr(OP_AUIPC,  1'b0, 0, 0, -1);
    run_instr(7'h7F,     1'b0, 0, 0, -1);
    run_halt_req(OP_R);
    run_instr(OP_IMM,    1'b0, 3, 0, -1);   // longest fetch stall that survives
    run_instr(OP_IMM,    1'b0, 4, 0, -1);   // fetch timeout
    run_instr(OP_IMM,    1'b0, 0, 0, -1);
    run_instr(OP_LOAD,   1'b0, 0, 3, 2);    // reset pulse in the middle of MEM
    run_instr(OP_STORE,  1'b0, 0, 0, -1);
    run_instr(OP_LOAD,   1'b0, 0, 5, -1);   // data timeout

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(10, 0);
      if (sel < 9) opc = ops[sel];
      else         opc = ro();
      iw = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 0);
      dw = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 0);
      run_instr(opc, rb(), iw, dw, -1);
    end

    stim_done = 1'b1;
  end

endmodule
